wb_wport_arbiter: RTL and testbench



---
 rtl/wb_wport_arbiter_pkg.sv | 20 ++
 rtl/wb_ext_fifo.sv | 72 +++++++
 rtl/wb_wport_arbiter.sv | 116 +++++++++++
 tb/tb_wb_wport_arbiter.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_wport_arbiter_pkg.sv
package wb_wport_arbiter_pkg;

  localparam int DBITS     = 32;
  localparam int REGNOBITS = 5;

  typedef struct packed {
    logic [REGNOBITS-1:0] regno;
    logic [DBITS-1:0]     val;
    logic                 live;
  } wport_entry_t;

  localparam int WPORT_ENTRY_W = REGNOBITS + DBITS + 1;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_PIPE,
    GNT_EXT
  } gnt_e;

endpackage

// File: rtl/wb_ext_fifo.sv
module wb_ext_fifo #(
  parameter int DBITS     = 32,
  parameter int REGNOBITS = 5,
  parameter int DEPTH     = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push,
  input  logic [REGNOBITS-1:0] push_regno,
  input  logic [DBITS-1:0]     push_val,
  input  logic                 pop,
  input  logic                 squash_en,
  input  logic [REGNOBITS-1:0] squash_regno,
  output logic                 full,
  output logic                 head_valid,
  output logic                 head_live,
  output logic [REGNOBITS-1:0] head_regno,
  output logic [DBITS-1:0]     head_val
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [REGNOBITS-1:0] regno_q [DEPTH];
  logic [DBITS-1:0]     val_q   [DEPTH];
  logic [DEPTH-1:0]     live_q;
  logic [AW-1:0]        head_q;
  logic [AW-1:0]        tail_q;
  logic [AW:0]          count_q;
  logic                 do_push;
  logic                 do_pop;

  always_comb begin
    full       = (count_q == (AW+1)'(DEPTH));
    head_valid = (count_q != '0);
    head_live  = head_valid && live_q[head_q];
    head_regno = regno_q[head_q];
    head_val   = val_q[head_q];
    do_push    = push && !full;
    do_pop     = pop && head_valid;
  end

  // An entry written in the same cycle as a matching squash is stored already dead.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      live_q  <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (squash_en && (regno_q[AW'(i)] == squash_regno)) begin
          live_q[AW'(i)] <= 1'b0;
        end
      end
      if (do_push) begin
        regno_q[tail_q] <= push_regno;
        val_q[tail_q]   <= push_val;
        live_q[tail_q]  <= !(squash_en && (push_regno == squash_regno));
        tail_q          <= tail_q + AW'(1);
      end
      if (do_pop) begin
        head_q <= head_q + AW'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/wb_wport_arbiter.sv
module wb_wport_arbiter
  import wb_wport_arbiter_pkg::*;
#(
  parameter int DBITS        = wb_wport_arbiter_pkg::DBITS,
  parameter int REGNOBITS    = wb_wport_arbiter_pkg::REGNOBITS,
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pipe_wr_reg,
  input  logic [REGNOBITS-1:0] pipe_wregno,
  input  logic [DBITS-1:0]     pipe_regval,
  output logic                 pipe_ready,
  input  logic                 ext_valid,
  input  logic [REGNOBITS-1:0] ext_wregno,
  input  logic [DBITS-1:0]     ext_val,
  output logic                 ext_ready,
  output logic                 wr_reg_out,
  output logic [REGNOBITS-1:0] wregno_out,
  output logic [DBITS-1:0]     regval_out,
  output logic                 starve_active
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  gnt_e                 gnt;
  logic                 full;
  logic                 head_valid;
  logic                 head_live;
  logic [REGNOBITS-1:0] head_regno;
  logic [DBITS-1:0]     head_val;
  logic                 force_ext;
  logic                 pipe_req;
  logic                 fifo_push;
  logic                 fifo_pop;
  logic                 squash_en;
  logic [SW-1:0]        starve_cnt_q;
  logic [SW-1:0]        starve_cnt_d;

  wb_ext_fifo #(
    .DBITS     (DBITS),
    .REGNOBITS (REGNOBITS),
    .DEPTH     (DEPTH)
  ) u_fifo (
    .clk          (clk),
    .reset        (reset),
    .push         (fifo_push),
    .push_regno   (ext_wregno),
    .push_val     (ext_val),
    .pop          (fifo_pop),
    .squash_en    (squash_en),
    .squash_regno (pipe_wregno),
    .full         (full),
    .head_valid   (head_valid),
    .head_live    (head_live),
    .head_regno   (head_regno),
    .head_val     (head_val)
  );

  always_comb begin
    gnt           = GNT_NONE;
    pipe_ready    = 1'b1;
    starve_active = 1'b0;
    force_ext     = head_live && (starve_cnt_q >= LIMIT);
    pipe_req      = pipe_wr_reg && (pipe_wregno != '0);
    if (!reset) begin
      if (force_ext) begin
        gnt           = GNT_EXT;
        pipe_ready    = 1'b0;
        starve_active = 1'b1;
      end else if (pipe_req) begin
        gnt = GNT_PIPE;
      end else if (head_live) begin
        gnt = GNT_EXT;
      end
    end

    wr_reg_out = (gnt != GNT_NONE);
    wregno_out = '0;
    regval_out = '0;
    unique case (gnt)
      GNT_PIPE: begin
        wregno_out = pipe_wregno;
        regval_out = pipe_regval;
      end
      GNT_EXT: begin
        wregno_out = head_regno;
        regval_out = head_val;
      end
      default: ;
    endcase

    ext_ready = !reset && !full;
    fifo_push = ext_valid && ext_ready && (ext_wregno != '0);
    fifo_pop  = !reset && head_valid && ((gnt == GNT_EXT) || !head_live);
    squash_en = (gnt == GNT_PIPE);

    starve_cnt_d = starve_cnt_q;
    if ((gnt == GNT_EXT) || !head_live) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q < LIMIT) begin
      starve_cnt_d = starve_cnt_q + SW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

endmodule

// File: tb/tb_wb_wport_arbiter.sv
module tb_wb_wport_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        pipe_wr_reg;
  logic [4:0]  pipe_wregno;
  logic [31:0] pipe_regval;
  logic        pipe_ready;
  logic        ext_valid;
  logic [4:0]  ext_wregno;
  logic [31:0] ext_val;
  logic        ext_ready;
  logic        wr_reg_out;
  logic [4:0]  wregno_out;
  logic [31:0] regval_out;
  logic        starve_active;

  typedef struct packed {
    logic [4:0]  regno;
    logic [31:0] val;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  checks = 0;
  int  errors = 0;

  wb_wport_arbiter #(
    .DBITS        (32),
    .REGNOBITS    (5),
    .DEPTH        (4),
    .STARVE_LIMIT (8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .pipe_wr_reg   (pipe_wr_reg),
    .pipe_wregno   (pipe_wregno),
    .pipe_regval   (pipe_regval),
    .pipe_ready    (pipe_ready),
    .ext_valid     (ext_valid),
    .ext_wregno    (ext_wregno),
    .ext_val       (ext_val),
    .ext_ready     (ext_ready),
    .wr_reg_out    (wr_reg_out),
    .wregno_out    (wregno_out),
    .regval_out    (regval_out),
    .starve_active (starve_active)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_reg_out === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got r%0d=0x%0h, expected no write", wregno_out, regval_out);
      end else begin
        mon_e = exp_q.pop_front();
        if (wregno_out !== mon_e.regno || regval_out !== mon_e.val) begin
          errors++;
          $display("FAIL port_write: got r%0d=0x%0h, expected r%0d=0x%0h",
                   wregno_out, regval_out, mon_e.regno, mon_e.val);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic pipe(input logic wr, input int regno, input int val);
    pipe_wr_reg = wr;
    pipe_wregno = 5'(regno);
    pipe_regval = 32'(val);
  endtask

  task automatic ext(input logic v, input int regno, input int val);
    ext_valid  = v;
    ext_wregno = 5'(regno);
    ext_val    = 32'(val);
  endtask

  task automatic expect_wr(input int regno, input int val);
    wr_t e;
    e.regno = 5'(regno);
    e.val   = 32'(val);
    exp_q.push_back(e);
  endtask

  initial begin
    int v;
    reset = 1'b1;
    pipe(1'b1, 3, 32'h99);
    ext(1'b1, 0, 32'h55);

    for (int i = 0; i < 3; i++) begin
      cyc();
      settle();
      chk("rst_ext_ready", 32'(ext_ready), 32'd0);
      chk("rst_wr_reg", 32'(wr_reg_out), 32'd0);
      chk("rst_pipe_ready", 32'(pipe_ready), 32'd1);
      chk("rst_starve", 32'(starve_active), 32'd0);
      chk("rst_wregno", 32'(wregno_out), 32'd0);
      chk("rst_regval", regval_out, 32'd0);
    end

    cyc();
    reset = 1'b0;
    pipe(1'b0, 0, 0);
    settle();
    chk("post_rst_ext_ready", 32'(ext_ready), 32'd1);
    chk("post_rst_wr_reg", 32'(wr_reg_out), 32'd0);
    cyc();
    ext(1'b0, 0, 0);
    settle();
    chk("ext_r0_not_queued", 32'(wr_reg_out), 32'd0);

    cyc();
    ext(1'b1, 5, 32'h11);
    settle();
    chk("no_bypass", 32'(wr_reg_out), 32'd0);
    cyc();
    ext(1'b0, 0, 0);
    expect_wr(5, 32'h11);
    settle();
    chk("idle_ext_grant", 32'(wr_reg_out), 32'd1);
    chk("idle_pipe_ready", 32'(pipe_ready), 32'd1);
    cyc();
    settle();
    chk("idle_after", 32'(wr_reg_out), 32'd0);

    for (int i = 0; i <= 10; i++) begin
      cyc();
      ext(i == 0, 7, 32'hAA);
      v = (i == 10) ? 32'h309 : 32'h300 + i;
      pipe(1'b1, 3, v);
      if (i == 9) expect_wr(7, 32'hAA);
      else        expect_wr(3, v);
      settle();
      chk("starve_pipe_ready", 32'(pipe_ready), (i == 9) ? 32'd0 : 32'd1);
      chk("starve_active", 32'(starve_active), (i == 9) ? 32'd1 : 32'd0);
    end
    cyc();
    pipe(1'b0, 0, 0);
    settle();
    chk("starve_after", 32'(wr_reg_out), 32'd0);

    cyc();
    ext(1'b1, 9, 32'h1);
    pipe(1'b1, 3, 32'h400);
    expect_wr(3, 32'h400);
    settle();
    cyc();
    ext(1'b0, 0, 0);
    pipe(1'b1, 9, 32'h2);
    expect_wr(9, 32'h2);
    settle();
    chk("waw_pipe_ready", 32'(pipe_ready), 32'd1);
    cyc();
    pipe(1'b0, 0, 0);
    settle();
    chk("waw_squashed_pop", 32'(wr_reg_out), 32'd0);
    cyc();
    settle();
    chk("waw_empty", 32'(wr_reg_out), 32'd0);

    for (int i = 0; i <= 10; i++) begin
      cyc();
      ext(i < 4, 10 + i, 32'hA0 + i);
      v = (i == 10) ? 32'h509 : 32'h500 + i;
      pipe(1'b1, 3, v);
      if (i == 9) expect_wr(10, 32'hA0);
      else        expect_wr(3, v);
      settle();
      chk("fill_ext_ready", 32'(ext_ready), (i >= 4 && i <= 9) ? 32'd0 : 32'd1);
      chk("fill_pipe_ready", 32'(pipe_ready), (i == 9) ? 32'd0 : 32'd1);
    end
    for (int j = 1; j <= 3; j++) begin
      cyc();
      pipe(1'b0, 0, 0);
      expect_wr(10 + j, 32'hA0 + j);
      settle();
      chk("drain_wr", 32'(wr_reg_out), 32'd1);
    end
    cyc();
    settle();
    chk("drain_done", 32'(wr_reg_out), 32'd0);

    cyc();
    ext(1'b1, 4, 32'h33);
    pipe(1'b1, 3, 32'h600);
    expect_wr(3, 32'h600);
    settle();
    cyc();
    ext(1'b1, 0, 32'hBEEF);
    pipe(1'b1, 0, 32'hDEAD);
    expect_wr(4, 32'h33);
    settle();
    chk("r0_pipe_ready", 32'(pipe_ready), 32'd1);
    chk("r0_ext_ready", 32'(ext_ready), 32'd1);
    chk("r0_ext_wregno", 32'(wregno_out), 32'd4);
    cyc();
    ext(1'b0, 0, 0);
    pipe(1'b0, 0, 0);
    settle();
    chk("r0_after", 32'(wr_reg_out), 32'd0);

    cyc();
    ext(1'b1, 12, 32'h77);
    pipe(1'b1, 3, 32'h700);
    expect_wr(3, 32'h700);
    settle();
    cyc();
    reset = 1'b1;
    ext(1'b0, 0, 0);
    pipe(1'b0, 0, 0);
    settle();
    chk("midrst_wr", 32'(wr_reg_out), 32'd0);
    chk("midrst_ext_ready", 32'(ext_ready), 32'd0);
    cyc();
    reset = 1'b0;
    settle();
    chk("midrst_flushed", 32'(wr_reg_out), 32'd0);
    chk("midrst_ext_ready_back", 32'(ext_ready), 32'd1);
    cyc();
    settle();
    chk("midrst_idle", 32'(wr_reg_out), 32'd0);

    cyc();
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
